rps_match_controller: RTL
=========================

// Module: rps_match_controller
// PURPOSE
//  Sequences a best-of-N Rock-Paper-Scissors match around the combinational game datapath.
//  Runs a per-round countdown, then pulses sample_en so choices (and the bot pick) freeze.
//  Captures the datapath winner code, keeps scores and the round count, and declares the match winner.
//  Sits between the board UI (start/abort buttons, tick time base) and the game datapath/traffic-light display.
// PARAMETERS
//  WIN_TARGET   2  round wins that end the match (2 = best of 3)
//  MAX_ROUNDS   5  counted rounds (wins + draws) after which the match ends regardless
//  COUNT_TICKS  3  countdown length in ticks, 1..3
//  SHOW_TICKS   2  ticks a round result is held before the next round, >=1
//  SCORE_W      3  score counter width; must hold WIN_TARGET
//  RND_W        3  round counter width; must hold MAX_ROUNDS
// PORTS
//  Clk           in   1        system clock, all state on rising edge
//  Rst_n         in   1        asynchronous active-low reset
//  tick          in   1        1-cycle time-base strobe (e.g. 1 Hz enable)
//  start         in   1        level/pulse; starts a match from IDLE or DONE
//  abort         in   1        returns to IDLE from any state
//  winner_in     in   3        datapath result: 100 P1, 001 P2, 010 draw, 000 invalid
//  sample_en     out  1        1-cycle pulse: datapath/bot snapshot player choices
//  countdown     out  2        remaining countdown ticks, for display
//  round_result  out  3        last captured round code (same encoding as winner_in)
//  p1_score      out  SCORE_W  player 1 round wins
//  p2_score      out  SCORE_W  player 2 round wins
//  round_cnt     out  RND_W    counted rounds (void rounds excluded)
//  match_over    out  1        high in DONE
//  match_winner  out  3        100 P1, 001 P2, 010 draw, 000 while match not over
// BEHAVIOUR
//  Reset (Rst_n=0, async): state IDLE; all outputs 0; internal tick counter 0.
//  States: IDLE -> COUNTDOWN -> EVAL -> SHOW -> (COUNTDOWN | DONE); DONE -> COUNTDOWN.
//  IDLE: start=1 -> scores/round_cnt/round_result cleared, countdown<=COUNT_TICKS, go COUNTDOWN.
//  COUNTDOWN: each tick decrements countdown. A tick with countdown==1 sets countdown<=0 and
//   goes to EVAL; sample_en is registered high for exactly the EVAL cycle.
//  EVAL (exactly 1 cycle): winner_in sampled at the end of the cycle.
//   100/001 -> corresponding score +1, round_cnt +1. 010 -> round_cnt +1 only.
//   000 -> void round: no counter change. round_result <= winner_in in every case. Go to SHOW.
//  SHOW: held for SHOW_TICKS ticks, counted from the first tick after entry. On the final tick:
//   if p1_score==WIN_TARGET, p2_score==WIN_TARGET or round_cnt==MAX_ROUNDS -> DONE,
//   else countdown<=COUNT_TICKS and go COUNTDOWN.
//  DONE: match_over=1; match_winner is the higher score, 010 if the scores are equal;
//   registered on DONE entry, and the scores stay frozen.
//   start -> same clearing as IDLE, then COUNTDOWN; match_over/match_winner drop to 0.
//  Priority: abort > start > tick. abort in any state -> IDLE with every output cleared next cycle.
//  start is ignored outside IDLE/DONE; tick is ignored in IDLE/EVAL/DONE.
//  Counters never wrap: the exit checks guarantee no increment past WIN_TARGET/MAX_ROUNDS.
//  An unreachable state encoding recovers to IDLE.
// STRUCTURE
//  Shared package rps_pkg: choice codes (ROCK 001, SCISSORS 010, PAPER 100, EMPTY 000),
//   result codes (P1_WIN 100, P2_WIN 001, DRAW 010, NO_WINNER 000), controller state encoding.
//  One sub-module: rps_tick_timer (load value, tick-driven down-counter, done flag),
//   shared by COUNTDOWN and SHOW.
//  Next-state logic is one combinational block; state and counters sit in one sequential block.
// TESTING
//  1 Reset mid-COUNTDOWN (Rst_n low 1 cycle) -> all outputs 0, state IDLE at once; later ticks do nothing.
//  2 start, 3 ticks, winner_in=100 twice -> sample_en pulses twice; p1_score 1 then 2;
//    after SHOW, match_over=1, match_winner=100, round_cnt=2.
//  3 Rounds 010,010,001,100,010 -> round_cnt reaches 5, scores 1/1, DONE with match_winner=010.
//  4 winner_in=000 in EVAL -> round_result=000, scores and round_cnt unchanged, next COUNTDOWN reloads to 3.
//  5 abort on the same cycle as tick with countdown==1 -> IDLE, no sample_en, outputs cleared.
//  6 start asserted during SHOW -> ignored; start in DONE -> scores cleared, countdown=3, match_over=0.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared Rock-Paper-Scissors codes and match controller state encoding.
package rps_pkg;

   localparam logic [2:0] ROCK      = 3'b001;
   localparam logic [2:0] SCISSORS  = 3'b010;
   localparam logic [2:0] PAPER     = 3'b100;
   localparam logic [2:0] EMPTY     = 3'b000;

   localparam logic [2:0] P1_WIN    = 3'b100;
   localparam logic [2:0] P2_WIN    = 3'b001;
   localparam logic [2:0] DRAW      = 3'b010;
   localparam logic [2:0] NO_WINNER = 3'b000;

   // Wide enough for both the countdown and the result hold time
   localparam int TMR_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_EVAL      = 3'd2,
      ST_SHOW      = 3'd3,
      ST_DONE      = 3'd4
   } ctrl_state_e;

endpackage

// File: rtl/rps_tick_timer.sv
// Loadable tick-driven down-counter; done flags the tick that consumes the last count.
module rps_tick_timer
   import rps_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         run,
   output logic [W-1:0] count,
   output logic         done
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (run && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign done  = run && (count_q == W'(1));

endmodule

// File: rtl/rps_match_controller.sv
// Best-of-N Rock-Paper-Scissors match sequencer: countdown, sample, score, declare winner.
module rps_match_controller
   import rps_pkg::*;
#(
   parameter int WIN_TARGET  = 2,
   parameter int MAX_ROUNDS  = 5,
   parameter int COUNT_TICKS = 3,
   parameter int SHOW_TICKS  = 2,
   parameter int SCORE_W     = 3,
   parameter int RND_W       = 3
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               tick,
   input  logic               start,
   input  logic               abort,
   input  logic [2:0]         winner_in,
   output logic               sample_en,
   output logic [1:0]         countdown,
   output logic [2:0]         round_result,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [RND_W-1:0]   round_cnt,
   output logic               match_over,
   output logic [2:0]         match_winner
);

   ctrl_state_e        state_q, state_d;
   logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
   logic [RND_W-1:0]   rnd_q, rnd_d;
   logic [2:0]         result_q, result_d;
   logic [2:0]         mwin_q, mwin_d;
   logic               sample_q, sample_d;

   logic               tmr_load, tmr_run, tmr_done;
   logic [TMR_W-1:0]   tmr_val, tmr_cnt;

   function automatic logic [2:0] pick_winner(input logic [SCORE_W-1:0] a,
                                              input logic [SCORE_W-1:0] b);
      if (a > b)      return P1_WIN;
      else if (b > a) return P2_WIN;
      else            return DRAW;
   endfunction

   rps_tick_timer #(.W(TMR_W)) u_timer (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .run      (tmr_run),
      .count    (tmr_cnt),
      .done     (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      rnd_d    = rnd_q;
      result_d = result_q;
      mwin_d   = mwin_q;
      sample_d = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_run  = 1'b0;

      if (abort) begin
         state_d  = ST_IDLE;
         p1_d     = '0;
         p2_d     = '0;
         rnd_d    = '0;
         result_d = NO_WINNER;
         mwin_d   = NO_WINNER;
         tmr_load = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d  = ST_COUNTDOWN;
                  p1_d     = '0;
                  p2_d     = '0;
                  rnd_d    = '0;
                  result_d = NO_WINNER;
                  mwin_d   = NO_WINNER;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(COUNT_TICKS);
               end
            end
            ST_COUNTDOWN: begin
               tmr_run = tick;
               if (tmr_done) begin
                  state_d  = ST_EVAL;
                  sample_d = 1'b1;
               end
            end
            ST_EVAL: begin
               // Invalid or empty codes void the round: only the display code updates
               case (winner_in)
                  P1_WIN: begin
                     p1_d  = p1_q + SCORE_W'(1);
                     rnd_d = rnd_q + RND_W'(1);
                  end
                  P2_WIN: begin
                     p2_d  = p2_q + SCORE_W'(1);
                     rnd_d = rnd_q + RND_W'(1);
                  end
                  DRAW:    rnd_d = rnd_q + RND_W'(1);
                  default: ;
               endcase
               result_d = winner_in;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(SHOW_TICKS);
               state_d  = ST_SHOW;
            end
            ST_SHOW: begin
               tmr_run = tick;
               if (tmr_done) begin
                  if ((p1_q == SCORE_W'(WIN_TARGET)) || (p2_q == SCORE_W'(WIN_TARGET)) ||
                      (rnd_q == RND_W'(MAX_ROUNDS))) begin
                     state_d = ST_DONE;
                     mwin_d  = pick_winner(p1_q, p2_q);
                  end else begin
                     state_d  = ST_COUNTDOWN;
                     tmr_load = 1'b1;
                     tmr_val  = TMR_W'(COUNT_TICKS);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= ST_IDLE;
         p1_q     <= '0;
         p2_q     <= '0;
         rnd_q    <= '0;
         result_q <= NO_WINNER;
         mwin_q   <= NO_WINNER;
         sample_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         rnd_q    <= rnd_d;
         result_q <= result_d;
         mwin_q   <= mwin_d;
         sample_q <= sample_d;
      end
   end

   always_comb begin
      countdown    = (state_q == ST_COUNTDOWN) ? tmr_cnt[1:0] : 2'b00;
      match_over   = (state_q == ST_DONE);
      sample_en    = sample_q;
      round_result = result_q;
      p1_score     = p1_q;
      p2_score     = p2_q;
      round_cnt    = rnd_q;
      match_winner = mwin_q;
   end

endmodule
